// File: rtl/dxi_pkg.sv
// rtl/dxi_pkg.sv - shared pixel/window types for the DXI window generator and filter
package dxi_pkg;

    localparam int PIX_W = 8;
    localparam int WIN_N = 9;
    localparam int WIN_W = PIX_W * WIN_N;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [WIN_W-1:0] window_t;

    // Slide the 3x3 one column left; the new right column is {top, mid, bot}.
    function automatic window_t win_shift(input window_t w, input pixel_t top,
                                          input pixel_t mid, input pixel_t bot);
        return {bot, w[71:64], w[63:56],
                mid, w[47:40], w[39:32],
                top, w[23:16], w[15:8]};
    endfunction

endpackage

// File: rtl/dxi_line_buffer.sv
// rtl/dxi_line_buffer.sv - one image row of pixels, synchronous write, combinational read
module dxi_line_buffer
    import dxi_pkg::*;
#(
    parameter int DEPTH = 640,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    // Contents are intentionally not reset; position gating upstream hides stale data.
    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dxi_window_gen.sv
// rtl/dxi_window_gen.sv - raster pixel stream to 3x3 window stream for the DXI filter
module dxi_window_gen
    import dxi_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_dxi_valid,
    input  logic [PIX_W-1:0] i_dxi_data,
    output logic             o_dxi_ready,
    output logic             o_dxi_out_valid,
    output logic [WIN_W-1:0] o_window_data,
    input  logic             i_dxi_out_ready,
    output logic             o_win_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    pixel_t        lb1_rd;
    pixel_t        lb2_rd;
    window_t       col_reg;
    window_t       win_next;
    logic          accept;
    logic          stream;
    logic          emit;
    logic          at_col_end;
    logic          at_frame_end;

    // Single output register: a pixel may enter only if the held window leaves this cycle.
    assign o_dxi_ready  = i_rstn && (!o_dxi_out_valid || i_dxi_out_ready);
    assign accept       = i_dxi_valid && o_dxi_ready;
    assign stream       = (row >= RW'(2));
    assign at_col_end   = (col == COL_LAST);
    assign at_frame_end = at_col_end && (row == ROW_LAST);
    assign emit         = accept && stream && (col >= CW'(2));
    assign win_next     = win_shift(col_reg, lb2_rd, lb1_rd, i_dxi_data);

    // LB1 holds row r-1, LB2 holds row r-2; LB1's old value cascades into LB2.
    dxi_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk   (i_clk),
        .we    (accept),
        .addr  (col),
        .wdata (i_dxi_data),
        .rdata (lb1_rd)
    );

    dxi_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb2 (
        .clk   (i_clk),
        .we    (accept),
        .addr  (col),
        .wdata (lb1_rd),
        .rdata (lb2_rd)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            col             <= '0;
            row             <= '0;
            col_reg         <= '0;
            o_dxi_out_valid <= 1'b0;
            o_window_data   <= '0;
            o_win_last      <= 1'b0;
        end else begin
            if (accept) begin
                col_reg <= win_next;
                if (at_frame_end) begin
                    col <= '0;
                    row <= '0;
                end else if (at_col_end) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            if (emit) begin
                o_dxi_out_valid <= 1'b1;
                o_window_data   <= win_next;
                o_win_last      <= at_frame_end;
            end else if (i_dxi_out_ready) begin
                o_dxi_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dxi_window_gen.md
# dxi_window_gen

Raster-to-window stage directly upstream of the DXI 3x3 filter (`dxi_top`). It accepts an 8-bit pixel stream in raster order over a DXI valid/ready handshake and buffers the two previous image rows. For every fully populated 3x3 neighbourhood it emits one 72-bit window, in the same packing the filter consumes. There is no border padding: a W x H frame yields (W-2)*(H-2) windows.

## Interface
- `IMG_WIDTH`, default 640: pixels per row. Must be ≥3.
- `IMG_HEIGHT`, default 480: rows per frame. Must be ≥3.

Ports (name, direction, width, meaning):
- `i_clk`  in  1  sole clock; all logic on its rising edge.
- `i_rstn`  in  1  reset; synchronous and active-low.
- `i_dxi_valid`  in  1  input pixel valid.
- `i_dxi_data`  in  8  input pixel.
- `o_dxi_ready`  out  1  stage can accept a pixel.
- `o_dxi_out_valid`  out  1  window valid toward the filter.
- `o_window_data`  out  72  3x3 window.
- `i_dxi_out_ready`  in  1  filter accepts the window.
- `o_win_last`  out  1  qualifies the last window of a frame.

## Operation
- **Acceptance:** a pixel is accepted on a rising edge where `i_dxi_valid && o_dxi_ready`.
- **Position counters:**
  - `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) track the position of the next pixel.
  - Counters advance only on acceptance.
  - At `col==IMG_WIDTH-1`, `col` wraps to 0 and `row` increments.
  - At (`row==IMG_HEIGHT-1`, `col==IMG_WIDTH-1`), both wrap to 0. The next frame starts with no other action.
- **Phases (derived from `row`):**
  - FILL (`row<2`): pixels only populate the line buffers.
  - STREAM (`row>=2`): windows are produced.
  - FILL→STREAM when `row` becomes 2. STREAM→FILL on frame wrap.
- **Line buffers:** two buffers of IMG_WIDTH × 8 bits, LB1 holding row r-1 and LB2 holding row r-2. On acceptance at column c:
  - Read `LB2[c]` and `LB1[c]` combinationally.
  - Shift a 3x3 column register left by one column. The new right column is {`LB2[c]`, `LB1[c]`, pixel}, top to bottom.
  - Write `LB2[c] <= LB1[c]` and `LB1[c] <= pixel`.
- **Emission:**
  - An accepted pixel with `row>=2 && col>=2` loads the output register with the updated 3x3 and sets `o_dxi_out_valid`.
  - `o_win_last` is set when that pixel is the last of the frame.
- **Window packing:** element i occupies bits [i*8+7 : i*8].
  - i=0 is top-left (row r-2, column c-2), in raster order.
  - i=4 is the centre.
  - i=8 is the newest pixel (row r, column c).
- **No arithmetic:** pixels are moved only, never modified. Line-buffer contents are not reset; column/position gating guarantees that stale data never reaches an emitted window.

## Timing
- **Reset values:** `o_dxi_out_valid`=0, `o_win_last`=0, `o_window_data`=0, `col`=0, `row`=0, column register 0.
  - `o_dxi_ready`=1 out of reset.
  - While `i_rstn`=0, `o_dxi_ready` is held 0.
- **Ready rule:** `o_dxi_ready = !o_dxi_out_valid || i_dxi_out_ready` (single output register).
- **Latency:** the window appears 1 cycle after the accepting edge of its bottom-right pixel.
- **Throughput:** 1 pixel/cycle while `i_dxi_out_ready`=1. A window handshake and a new pixel acceptance in the same cycle are legal; the output register reloads without a bubble.
- **Output hold:** while `o_dxi_out_valid && !i_dxi_out_ready`, `o_window_data` and `o_win_last` are held stable and no pixel is accepted.
- **Valid clear:** `o_dxi_out_valid` clears after the handshake unless a new window loads on the same edge.
- **Reset mid-frame:** partial windows are discarded, counters restart at (0,0), and the next pixel is treated as frame start.

## Structure
- Shared package `dxi_pkg`:
  - Constants `PIX_W`=8, `WIN_N`=9, `WIN_W`=72.
  - Types `pixel_t` and `window_t`.
  - Also consumed by the filter and the bench model.
- Sub-module `dxi_line_buffer`:
  - One row of IMG_WIDTH pixels, with write enable, address, write data and combinational read.
  - Instantiated twice (LB1, LB2).
- Top: counters, phase decode, column register, output register.

## Test plan
- **Basic frame:** W=H=4, pixels 0x00..0x0F, out_ready=1.
  - Exactly 4 windows.
  - First window `72'h0A0908060504020100`, 1 cycle after pixel 0x0A is accepted.
  - Last window `72'h0F0E0D0B0A09070605` with `o_win_last`=1; `o_win_last`=0 on the others.
- **Back-to-back frames:** second frame 0x10..0x1F sent immediately after the first.
  - First window `72'h1A1918161514121110`; no frame-1 data appears.
- **Backpressure:** out_ready=0 for 5 cycles after the first window.
  - `o_dxi_ready`=0 and the window is stable throughout.
  - On release, all 4 windows arrive in order with none lost or duplicated.
- **Bubbly input:** `i_dxi_valid` toggled 1/0 each cycle.
  - Same 4 windows as the basic frame; counters advance only on acceptance.
- **Reset mid-frame:** 6 pixels sent, then `i_rstn`=0 for 2 cycles.
  - Outputs read 0 during reset.
  - A subsequent 0x00..0x0F frame reproduces the basic-frame results exactly.
- **Full-rate check:** W=5, H=3, continuous valid/ready.
  - 3 windows on consecutive cycles after pixels 12, 13 and 14.
  - `o_win_last` set on the third window.
